// File: rtl/piano_note_arbiter.sv
// ============================================================================
// Module   : piano_note_arbiter
// Shares one tone generator between the live keyboard and the song players,
// with a forced silent gap on every change of source.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module piano_note_arbiter #(
    parameter int unsigned NUM_SONGS       = 4,
    parameter int unsigned SEL_W           = 2,
    parameter int unsigned KEY_W           = 4,
    parameter int unsigned GAP_CYCLES      = 1000000,
    parameter int unsigned MAX_PLAY_CYCLES = 32'd1300000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       live_on,
    input  logic [KEY_W-1:0]           live_key,
    input  logic [NUM_SONGS-1:0]       song_on,
    input  logic [NUM_SONGS*KEY_W-1:0] song_key,
    input  logic [SEL_W-1:0]           song_sel,
    input  logic                       play_req,
    input  logic                       stop_req,
    output logic [NUM_SONGS-1:0]       player_rst,
    output logic                       key_on,
    output logic [KEY_W-1:0]           key,
    output logic [1:0]                 src,
    output logic                       busy
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_live = 2'd1;
    localparam logic [1:0] c_st_song = 2'd2;
    localparam logic [1:0] c_st_gap  = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [SEL_W-1:0]     cur_sel_q, cur_sel_d;
    logic                 pending_q, pending_d;
    logic [31:0]          play_cnt_q, play_cnt_d;
    logic [31:0]          gap_cnt_q, gap_cnt_d;
    logic [NUM_SONGS-1:0] player_rst_q, player_rst_d;
    logic                 key_on_q, key_on_d;
    logic [KEY_W-1:0]     key_q, key_d;
    logic                 busy_q, busy_d;

    logic                 w_play_ok;
    logic                 w_sel_on;
    logic [KEY_W-1:0]     w_sel_key;

    // A stop in the same cycle cancels any play request.
    assign w_play_ok = play_req && !stop_req && (32'(song_sel) < NUM_SONGS);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= c_st_idle;
            cur_sel_q    <= '0;
            pending_q    <= 1'b0;
            play_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            player_rst_q <= '1;
            key_on_q     <= 1'b0;
            key_q        <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_sel_q    <= cur_sel_d;
            pending_q    <= pending_d;
            play_cnt_q   <= play_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            player_rst_q <= player_rst_d;
            key_on_q     <= key_on_d;
            key_q        <= key_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        cur_sel_d  = cur_sel_q;
        pending_d  = pending_q;
        play_cnt_d = '0;
        gap_cnt_d  = '0;
        case (state_q)
            c_st_idle: begin
                if (live_on) begin
                    state_d = c_st_live;
                end else if (w_play_ok) begin
                    cur_sel_d = song_sel;
                    state_d   = c_st_song;
                end
            end
            c_st_live: begin
                if (stop_req) begin
                    pending_d = 1'b0;
                end else if (w_play_ok) begin
                    cur_sel_d = song_sel;
                    pending_d = 1'b1;
                end
                if (!live_on) begin
                    state_d = c_st_gap;
                end
            end
            c_st_song: begin
                if (live_on || stop_req || (play_cnt_q == MAX_PLAY_CYCLES - 1)) begin
                    pending_d = 1'b0;
                    state_d   = c_st_gap;
                end else if (w_play_ok) begin
                    cur_sel_d = song_sel;
                    pending_d = 1'b1;
                    state_d   = c_st_gap;
                end else begin
                    play_cnt_d = play_cnt_q + 32'd1;
                end
            end
            default: begin
                if (stop_req) begin
                    pending_d = 1'b0;
                end else if (w_play_ok) begin
                    cur_sel_d = song_sel;
                    pending_d = 1'b1;
                end
                if (gap_cnt_q == GAP_CYCLES - 1) begin
                    if (live_on) begin
                        state_d = c_st_live;
                    end else if (pending_d) begin
                        pending_d = 1'b0;
                        state_d   = c_st_song;
                    end else begin
                        state_d = c_st_idle;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 32'd1;
                end
            end
        endcase
    end

    // Outputs are registered from the next state, giving one cycle of latency.
    always_comb begin
        w_sel_on  = 1'b0;
        w_sel_key = '0;
        for (int i = 0; i < NUM_SONGS; i++) begin
            if (cur_sel_d == SEL_W'(i)) begin
                w_sel_on  = song_on[i];
                w_sel_key = song_key[i*KEY_W +: KEY_W];
            end
        end

        player_rst_d = '1;
        key_on_d     = 1'b0;
        key_d        = key_q;
        busy_d       = (state_d != c_st_idle);
        case (state_d)
            c_st_live: begin
                key_on_d = live_on;
                key_d    = live_key;
            end
            c_st_song: begin
                key_on_d = w_sel_on;
                key_d    = w_sel_key;
                for (int i = 0; i < NUM_SONGS; i++) begin
                    player_rst_d[i] = (cur_sel_d != SEL_W'(i));
                end
            end
            default: begin
                key_on_d = 1'b0;
            end
        endcase
    end

    assign player_rst = player_rst_q;
    assign key_on     = key_on_q;
    assign key        = key_q;
    assign src        = state_q;
    assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_piano_note_arbiter.sv
// ============================================================================
// Module   : tb_piano_note_arbiter
// Directed bench for piano_note_arbiter (GAP_CYCLES=4, MAX_PLAY_CYCLES=100).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_piano_note_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        live_on;
    logic [3:0]  live_key;
    logic [3:0]  song_on;
    logic [15:0] song_key;
    logic [1:0]  song_sel;
    logic        play_req;
    logic        stop_req;
    logic [3:0]  player_rst;
    logic        key_on;
    logic [3:0]  key;
    logic [1:0]  src;
    logic        busy;

    logic        play_req3;
    logic [2:0]  player_rst3;
    logic        key_on3;
    logic [3:0]  key3;
    logic [1:0]  src3;
    logic        busy3;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    piano_note_arbiter #(
        .NUM_SONGS(4), .SEL_W(2), .KEY_W(4), .GAP_CYCLES(4), .MAX_PLAY_CYCLES(100)
    ) dut (
        .clk(clk), .rst(rst), .live_on(live_on), .live_key(live_key),
        .song_on(song_on), .song_key(song_key), .song_sel(song_sel),
        .play_req(play_req), .stop_req(stop_req), .player_rst(player_rst),
        .key_on(key_on), .key(key), .src(src), .busy(busy)
    );

    // Three-song instance used to exercise the out-of-range selection boundary.
    piano_note_arbiter #(
        .NUM_SONGS(3), .SEL_W(2), .KEY_W(4), .GAP_CYCLES(4), .MAX_PLAY_CYCLES(100)
    ) dut3 (
        .clk(clk), .rst(rst), .live_on(1'b0), .live_key(live_key),
        .song_on(song_on[2:0]), .song_key(song_key[11:0]), .song_sel(song_sel),
        .play_req(play_req3), .stop_req(1'b0), .player_rst(player_rst3),
        .key_on(key_on3), .key(key3), .src(src3), .busy(busy3)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; live_on = 1'b0; live_key = 4'h0; song_on = 4'h0; song_key = 16'h0;
        song_sel = 2'd0; play_req = 1'b0; stop_req = 1'b0; play_req3 = 1'b0;
        tick(2);
        chk("rst_src", src, 2'd0);
        chk("rst_key_on", key_on, 1'b0);
        chk("rst_key", key, 4'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_prst", player_rst, 4'b1111);
        rst = 1'b0;
        tick();

        // Song 2 plays to the time limit, then gap, then idle.
        song_on = 4'b0100; song_key = 16'h0500; song_sel = 2'd2; play_req = 1'b1;
        tick(); play_req = 1'b0;
        chk("t1_src", src, 2'd2);
        chk("t1_key", key, 4'h5);
        chk("t1_key_on", key_on, 1'b1);
        chk("t1_prst", player_rst, 4'b1011);
        chk("t1_busy", busy, 1'b1);
        tick(99);
        chk("t1_last_song", src, 2'd2);
        tick();
        chk("t1_gap_src", src, 2'd3);
        chk("t1_gap_key_on", key_on, 1'b0);
        chk("t1_gap_key", key, 4'h5);
        chk("t1_gap_prst", player_rst, 4'b1111);
        tick(3);
        chk("t1_gap_end", src, 2'd3);
        tick();
        chk("t1_idle_src", src, 2'd0);
        chk("t1_idle_busy", busy, 1'b0);

        // Live key preempts song 1; song is not resumed afterwards.
        song_on = 4'b0010; song_key = 16'h0090; song_sel = 2'd1; play_req = 1'b1;
        tick(); play_req = 1'b0;
        chk("t2_prst", player_rst, 4'b1101);
        chk("t2_key", key, 4'h9);
        tick(3);
        live_on = 1'b1; live_key = 4'h7;
        tick();
        chk("t2_pre_src", src, 2'd3);
        chk("t2_pre_key_on", key_on, 1'b0);
        tick(3);
        chk("t2_gap_end", src, 2'd3);
        tick();
        chk("t2_live_src", src, 2'd1);
        chk("t2_live_key", key, 4'h7);
        chk("t2_live_key_on", key_on, 1'b1);
        live_on = 1'b0;
        tick();
        chk("t2_rel_src", src, 2'd3);
        chk("t2_rel_key_on", key_on, 1'b0);
        tick(4);
        chk("t2_idle", src, 2'd0);

        // Switch from song 0 to song 3 through a gap.
        song_on = 4'b0001; song_key = 16'h0003; song_sel = 2'd0; play_req = 1'b1;
        tick(); play_req = 1'b0;
        chk("t3_prst0", player_rst, 4'b1110);
        song_on = 4'b1001; song_key = 16'hA003; song_sel = 2'd3; play_req = 1'b1;
        tick(); play_req = 1'b0;
        chk("t3_gap_src", src, 2'd3);
        chk("t3_gap_prst", player_rst, 4'b1111);
        tick(3);
        chk("t3_gap_end", src, 2'd3);
        tick();
        chk("t3_song_src", src, 2'd2);
        chk("t3_song_prst", player_rst, 4'b0111);
        chk("t3_song_key", key, 4'hA);
        chk("t3_song_key_on", key_on, 1'b1);
        stop_req = 1'b1;
        tick(); stop_req = 1'b0;
        chk("t3_stop_src", src, 2'd3);
        tick(4);
        chk("t3_idle", src, 2'd0);

        // Stop and play together: stop wins.
        song_on = 4'b0100; song_key = 16'h0500; song_sel = 2'd2; play_req = 1'b1;
        tick(); play_req = 1'b0;
        chk("t4_song", src, 2'd2);
        song_sel = 2'd1; play_req = 1'b1; stop_req = 1'b1;
        tick(); play_req = 1'b0; stop_req = 1'b0;
        chk("t4_gap", src, 2'd3);
        tick(4);
        chk("t4_idle", src, 2'd0);
        chk("t4_idle_busy", busy, 1'b0);

        // Selection beyond NUM_SONGS is ignored; the last valid one is accepted.
        song_sel = 2'd3; play_req3 = 1'b1;
        tick(); play_req3 = 1'b0;
        chk("t4_bad_src", src3, 2'd0);
        chk("t4_bad_prst", player_rst3, 3'b111);
        chk("t4_bad_busy", busy3, 1'b0);
        song_sel = 2'd2; play_req3 = 1'b1;
        tick(); play_req3 = 1'b0;
        chk("t4_ok_src", src3, 2'd2);
        chk("t4_ok_prst", player_rst3, 3'b011);

        // Play request during live playing starts the song after the gap.
        live_on = 1'b1; live_key = 4'h2;
        tick();
        chk("t5_live_src", src, 2'd1);
        chk("t5_live_key", key, 4'h2);
        song_sel = 2'd1; play_req = 1'b1;
        tick(); play_req = 1'b0;
        chk("t5_still_live", src, 2'd1);
        song_on = 4'b0010; song_key = 16'h0060; live_on = 1'b0;
        tick();
        chk("t5_gap", src, 2'd3);
        tick(3);
        chk("t5_gap_end", src, 2'd3);
        tick();
        chk("t5_song_src", src, 2'd2);
        chk("t5_song_key", key, 4'h6);
        chk("t5_song_prst", player_rst, 4'b1101);
        chk("t5_song_key_on", key_on, 1'b1);

        // Asynchronous reset mid-note silences at once.
        #2 rst = 1'b1;
        #1;
        chk("t6_key_on", key_on, 1'b0);
        chk("t6_src", src, 2'd0);
        chk("t6_prst", player_rst, 4'b1111);
        chk("t6_busy", busy, 1'b0);
        chk("t6_key", key, 4'h0);
        tick(2);
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
